bc1_block_fetch: RTL



---
 rtl/bc1_block_fetch_pkg.sv | 11 +
 rtl/bc1_block_fetch_if.sv | 29 ++
 rtl/bc1_block_fetch_tag_cache.sv | 38 +++
 rtl/bc1_block_fetch.sv | 100 ++++++++++
 4 files changed

// File: rtl/bc1_block_fetch_pkg.sv
// texture_pkg: shared BC1 block layout, block size and fetch FSM states.
package texture_pkg;
  localparam int BC1_BLOCK_BYTES = 8;
  localparam int BLK_SHIFT = $clog2(BC1_BLOCK_BYTES);
  typedef struct packed {
    logic [15:0] c1;
    logic [15:0] c0;
    logic [31:0] idx;
  } bc1_block_t;
  typedef enum logic [2:0] {IDLE, LOOKUP, MREQ, MWAIT, OUT} fetch_state_t;
endpackage

// File: rtl/bc1_block_fetch_if.sv
// bc1_block_fetch_if: request, memory and decoder-side handshakes of the block fetcher.
interface bc1_block_fetch_if #(parameter int ADDR_W = 32, parameter int COORD_W = 14);
  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_u;
  logic [COORD_W-1:0] req_v;
  logic [ADDR_W-1:0]  req_base;
  logic [COORD_W-3:0] req_pitch_blk;
  logic               inv;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_rsp_valid;
  logic [63:0]        mem_rsp_data;
  logic               out_valid;
  logic               out_ready;
  logic [63:0]        out_block;
  logic [3:0]         out_texel_idx;
  modport slave (
    input  req_valid, req_u, req_v, req_base, req_pitch_blk, inv,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
    output req_ready, mem_req_valid, mem_req_addr, out_valid, out_block, out_texel_idx
  );
  modport master (
    output req_valid, req_u, req_v, req_base, req_pitch_blk, inv,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
    input  req_ready, mem_req_valid, mem_req_addr, out_valid, out_block, out_texel_idx
  );
endinterface

// File: rtl/bc1_block_fetch_tag_cache.sv
// bc1_tag_cache: direct-mapped block cache, one lookup port, one fill port, global invalidate.
module bc1_tag_cache
  import texture_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          inv_i,
  input  logic [ADDR_W-BLK_SHIFT-1:0]   blk_i,
  output logic                          hit_o,
  output bc1_block_t                    rdata_o,
  input  logic                          fill_i,
  input  bc1_block_t                    fill_data_i
);
  localparam int TAG_W = ADDR_W - BLK_SHIFT - IDX_W;
  localparam int N = 2 ** IDX_W;
  logic [N-1:0]     valid_q;
  logic [TAG_W-1:0] tag_q [N];
  bc1_block_t       data_q [N];
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  assign idx = blk_i[IDX_W-1:0];
  assign tag = blk_i[ADDR_W-BLK_SHIFT-1 -: TAG_W];
  assign hit_o = valid_q[idx] && tag_q[idx] == tag;
  assign rdata_o = data_q[idx];
  // invalidate outranks a fill landing on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= '0;
    else if (inv_i) valid_q <= '0;
    else if (fill_i) valid_q[idx] <= 1'b1;
  always_ff @(posedge clk)
    if (fill_i) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= fill_data_i;
    end
endmodule

// File: rtl/bc1_block_fetch.sv
// bc1_block_fetch: texel coordinate -> BC1 block address, cached fetch, block out to decoder.
// Define BC1_FETCH_STATS_EN to add saturating hit/miss counters.
module bc1_block_fetch
  import texture_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int COORD_W = 14,
  parameter int IDX_W   = 3
) (
  input  logic clk,
  input  logic rst_n,
  bc1_block_fetch_if.slave bus
`ifdef BC1_FETCH_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);
  localparam int PW = COORD_W - 2;
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] blk_addr_q, blk_addr_d, addr_c;
  logic [3:0]        tidx_q, tidx_d;
  bc1_block_t        block_q, block_d, cache_data;
  logic              fsup_q, fsup_d, hit, fill;
  logic [2*PW-1:0]   prod_c;
  assign prod_c = PW'(bus.req_v >> 2) * bus.req_pitch_blk;
  assign addr_c = (bus.req_base & ~ADDR_W'(BC1_BLOCK_BYTES - 1))
                + ((ADDR_W'(prod_c) + ADDR_W'(bus.req_u >> 2)) << BLK_SHIFT);
  assign fill = state_q == MWAIT && bus.mem_rsp_valid && !fsup_q;
  // suppression spans the whole miss and is dropped when the response retires it
  assign fsup_d = (state_q == MWAIT && bus.mem_rsp_valid) ? 1'b0
                : (bus.inv && (state_q == MREQ || state_q == MWAIT)) ? 1'b1 : fsup_q;
  bc1_tag_cache #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_cache (
    .clk(clk),
    .rst_n(rst_n),
    .inv_i(bus.inv),
    .blk_i(blk_addr_q[ADDR_W-1:BLK_SHIFT]),
    .hit_o(hit),
    .rdata_o(cache_data),
    .fill_i(fill),
    .fill_data_i(bus.mem_rsp_data)
  );
  always_comb begin
    state_d    = state_q;
    blk_addr_d = blk_addr_q;
    tidx_d     = tidx_q;
    block_d    = block_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        blk_addr_d = addr_c;
        tidx_d     = {bus.req_v[1:0], bus.req_u[1:0]};
        state_d    = LOOKUP;
      end
      LOOKUP: begin
        block_d = hit ? cache_data : block_q;
        state_d = hit ? OUT : MREQ;
      end
      MREQ: state_d = bus.mem_req_ready ? MWAIT : MREQ;
      MWAIT: if (bus.mem_rsp_valid) begin
        block_d = bus.mem_rsp_data;
        state_d = OUT;
      end
      OUT: state_d = bus.out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      blk_addr_q <= '0;
      tidx_q     <= '0;
      block_q    <= '0;
      fsup_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_addr_q <= blk_addr_d;
      tidx_q     <= tidx_d;
      block_q    <= block_d;
      fsup_q     <= fsup_d;
    end
  assign bus.req_ready     = state_q == IDLE;
  assign bus.mem_req_valid = state_q == MREQ;
  assign bus.mem_req_addr  = blk_addr_q;
  assign bus.out_valid     = state_q == OUT;
  assign bus.out_block     = block_q;
  assign bus.out_texel_idx = tidx_q;
`ifdef BC1_FETCH_STATS_EN
  logic [31:0] hit_q, miss_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit && ~&hit_q) hit_q <= hit_q + 32'd1;
      if (!hit && ~&miss_q) miss_q <= miss_q + 32'd1;
    end
  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;
`endif
endmodule
